// File: rtl/apu_cluster_package.sv
// Shared APU cluster constants and types used by the cast result buffer.
//   FP_WIDTH       : floating-point result width
//   NUSFLAGS_CAST  : cast unit status flag count
//   CAST_RB_DEPTH  : default number of result buffer slots
//   CAST_TAG_WIDTH : widest tag the buffer storage can carry
//   cast_result_t  : one stored cast result {res, status, tag}
package apu_cluster_package;

    localparam int unsigned FP_WIDTH       = 32;
    localparam int unsigned NUSFLAGS_CAST  = 5;
    localparam int unsigned CAST_RB_DEPTH  = 4;
    localparam int unsigned CAST_TAG_WIDTH = 4;

    typedef struct packed {
        logic [FP_WIDTH-1:0]       res;
        logic [NUSFLAGS_CAST-1:0]  status;
        logic [CAST_TAG_WIDTH-1:0] tag;
    } cast_result_t;

endpackage

// File: rtl/fp_cast_result_buffer_if.sv
// Bundle of the cast result buffer handshake signals.
//   slave  : the buffer side (issue credit, cast result in, head result out,
//            fill/error status)
//   master : the surrounding pipeline / cast unit / consumer side
interface fp_cast_result_buffer_if
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH      = CAST_RB_DEPTH,
    parameter int unsigned TAG_WIDTH  = 1,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_CAST
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic                  res_valid_i;
    logic [FP_WIDTH-1:0]   res_i;
    logic [STAT_WIDTH-1:0] status_i;
    logic [TAG_WIDTH-1:0]  tag_i;
    logic                  out_valid_o;
    logic [FP_WIDTH-1:0]   out_res_o;
    logic [STAT_WIDTH-1:0] out_status_o;
    logic [TAG_WIDTH-1:0]  out_tag_o;
    logic                  out_ready_i;
    logic [CW-1:0]         fill_o;
    logic [1:0]            err_o;
    logic                  clr_err_i;

    modport slave (
        input  issue_valid_i, res_valid_i, res_i, status_i, tag_i,
               out_ready_i, clr_err_i,
        output issue_ready_o, out_valid_o, out_res_o, out_status_o,
               out_tag_o, fill_o, err_o
    );

    modport master (
        output issue_valid_i, res_valid_i, res_i, status_i, tag_i,
               out_ready_i, clr_err_i,
        input  issue_ready_o, out_valid_o, out_res_o, out_status_o,
               out_tag_o, fill_o, err_o
    );

endinterface

// File: rtl/fp_cast_rb_fifo.sv
// First-word-fall-through storage for cast results.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write data_i (ignored when full unless popping as well)
//   pop_i         : drop the head (ignored when empty)
//   data_i/data_o : entry in / head entry out (zero while empty)
//   count_o       : number of stored entries
//   full_o        : count_o == DEPTH
module fp_cast_rb_fifo
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH = CAST_RB_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  cast_result_t                 data_i,
    output cast_result_t                 data_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cast_result_t  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A push into a full buffer only lands when the head leaves the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = empty ? '0 : mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/fp_cast_result_buffer.sv
// Credit-managed result buffer behind the FP cast unit.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : issue credit (issue_valid_i/issue_ready_o), unstallable cast
//            result (res_valid_i, res_i, status_i, tag_i), head result
//            stream (out_valid_o/out_ready_i, out_res_o, out_status_o,
//            out_tag_o), fill_o, sticky err_o {spurious, overflow}, clr_err_i
module fp_cast_result_buffer
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH      = CAST_RB_DEPTH,
    parameter int unsigned TAG_WIDTH  = 1,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_CAST
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    fp_cast_result_buffer_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    cast_result_t  in_entry, head;
    logic [CW-1:0] fill;
    logic          full;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [1:0]    err_q, err_d;
    logic [SW-1:0] credit_sum;
    logic          issue_ready, issue_fire, pop_fire, out_valid;
    logic          overflow, spurious;

    always_comb begin
        in_entry        = '0;
        in_entry.res    = bus.res_i;
        in_entry.status = NUSFLAGS_CAST'(bus.status_i);
        in_entry.tag    = CAST_TAG_WIDTH'(bus.tag_i);
    end

    fp_cast_rb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.res_valid_i),
        .pop_i   (pop_fire),
        .data_i  (in_entry),
        .data_o  (head),
        .count_o (fill),
        .full_o  (full)
    );

    assign out_valid   = (fill != '0);
    assign pop_fire    = out_valid & bus.out_ready_i;
    // Registered counters only: a pop returns its credit on the next cycle.
    assign credit_sum  = {1'b0, fill} + {1'b0, inflight_q};
    assign issue_ready = (credit_sum < SW'(DEPTH));
    assign issue_fire  = bus.issue_valid_i & issue_ready;
    assign overflow    = bus.res_valid_i & full & ~pop_fire;
    assign spurious    = bus.res_valid_i & (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        if (issue_fire && !bus.res_valid_i) begin
            inflight_d = inflight_q + CW'(1);
        end else if (bus.res_valid_i && !issue_fire && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // Clear first, then OR in new events so a same-cycle error survives.
    always_comb begin
        err_d = bus.clr_err_i ? 2'b00 : err_q;
        err_d = err_d | {spurious, overflow};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            err_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.out_valid_o   = out_valid;
    assign bus.out_res_o     = head.res;
    assign bus.out_status_o  = STAT_WIDTH'(head.status);
    assign bus.out_tag_o     = TAG_WIDTH'(head.tag);
    assign bus.fill_o        = fill;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_fp_cast_result_buffer.sv
module tb_fp_cast_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 2;
    localparam int unsigned SW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_cast_result_buffer_if #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TW),
        .STAT_WIDTH (SW)
    ) bus ();

    fp_cast_result_buffer #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0]   r;
        logic [SW-1:0] s;
        logic [TW-1:0] t;
    } ent_t;

    // Reference model: queue of stored results, outstanding-op count, sticky errors.
    ent_t       mq[$];
    int         m_infl = 0;
    logic [1:0] m_err  = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        int fill;
        fill = mq.size();
        chk("out_valid",   32'(bus.out_valid_o),   32'(fill != 0));
        chk("fill",        32'(bus.fill_o),        32'(fill));
        chk("issue_ready", 32'(bus.issue_ready_o), 32'((fill + m_infl) < DEPTH));
        chk("err",         32'(bus.err_o),         32'(m_err));
        if (fill != 0) begin
            chk("out_res",    bus.out_res_o,          mq[0].r);
            chk("out_status", 32'(bus.out_status_o),  32'(mq[0].s));
            chk("out_tag",    32'(bus.out_tag_o),     32'(mq[0].t));
        end
    endtask

    // Check outputs against the model, advance the model with the driven inputs, clock once.
    task automatic step();
        int   n;
        bit   ready, fire, pop, push, ov, sp;
        ent_t e;
        compare_all();
        n     = mq.size();
        ready = (n + m_infl) < DEPTH;
        fire  = bus.issue_valid_i && ready;
        pop   = (n != 0) && bus.out_ready_i;
        push  = bus.res_valid_i;
        ov    = push && (n == DEPTH) && !pop;
        sp    = push && (m_infl == 0);
        if (pop) void'(mq.pop_front());
        if (push && !ov) begin
            e.r = bus.res_i;
            e.s = bus.status_i;
            e.t = bus.tag_i;
            mq.push_back(e);
        end
        if (fire && !push)                  m_infl++;
        else if (push && !fire && m_infl > 0) m_infl--;
        if (bus.clr_err_i) m_err = 2'b00;
        m_err = m_err | {sp, ov};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_i = 1'b0;
        bus.res_valid_i   = 1'b0;
        bus.res_i         = '0;
        bus.status_i      = '0;
        bus.tag_i         = '0;
        bus.out_ready_i   = 1'b0;
        bus.clr_err_i     = 1'b0;
    endtask

    task automatic drive_res(input logic [31:0] r, input logic [SW-1:0] s, input logic [TW-1:0] t);
        bus.res_valid_i = 1'b1;
        bus.res_i       = r;
        bus.status_i    = s;
        bus.tag_i       = t;
    endtask

    // Asynchronous reset mid-cycle: state must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid_o),  32'(0));
        chk("rst_fill",      32'(bus.fill_o),       32'(0));
        chk("rst_err",       32'(bus.err_o),        32'(0));
        chk("rst_out_res",   bus.out_res_o,         32'(0));
        chk("rst_out_stat",  32'(bus.out_status_o), 32'(0));
        chk("rst_out_tag",   32'(bus.out_tag_o),    32'(0));
        mq.delete();
        m_infl = 0;
        m_err  = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_issue_ready", 32'(bus.issue_ready_o), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // Four issues, results return two cycles later, consumer stalled.
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 4) bus.issue_valid_i = 1'b1;
            if (c >= 2 && c < 6) drive_res(32'h3F800000, SW'(c), TW'(c - 2));
            step();
        end
        chk("req030_fill",  32'(bus.fill_o),        32'(4));
        chk("req030_ready", 32'(bus.issue_ready_o), 32'(0));
        chk("req030_res",   bus.out_res_o,          32'h3F800000);
        chk("req030_tag",   32'(bus.out_tag_o),     32'(0));

        // Single pop from full; credit comes back the following cycle.
        idle();
        bus.out_ready_i = 1'b1;
        step();
        idle();
        chk("req031_fill",  32'(bus.fill_o),        32'(3));
        chk("req031_tag",   32'(bus.out_tag_o),     32'(1));
        chk("req031_ready", 32'(bus.issue_ready_o), 32'(1));
        step();

        // Refill to full, then push and pop together.
        idle();
        bus.issue_valid_i = 1'b1;
        step();
        idle();
        drive_res(32'h40000000, 5'h01, 2'd0);
        step();
        idle();
        bus.clr_err_i = 1'b1;
        step();
        idle();
        drive_res(32'h40400000, 5'h02, 2'd1);
        bus.out_ready_i = 1'b1;
        step();
        idle();
        chk("req032_fill", 32'(bus.fill_o),   32'(4));
        chk("req032_ovf",  32'(bus.err_o[0]), 32'(0));
        chk("req032_tag",  32'(bus.out_tag_o), 32'(2));

        // Push while full without a pop: dropped, overflow flagged, then cleared.
        drive_res(32'hDEADBEEF, 5'h1F, 2'd3);
        step();
        idle();
        chk("req033_ovf",  32'(bus.err_o[0]), 32'(1));
        chk("req033_fill", 32'(bus.fill_o),   32'(4));
        bus.clr_err_i = 1'b1;
        step();
        idle();
        chk("req033_clr", 32'(bus.err_o), 32'(0));
        for (int i = 0; i < 5; i++) begin
            bus.out_ready_i = 1'b1;
            step();
        end
        idle();

        // Spurious result right after reset.
        do_reset();
        drive_res(32'h3F000000, 5'h04, 2'd2);
        step();
        idle();
        chk("req034_spur",  32'(bus.err_o[1]),      32'(1));
        chk("req034_fill",  32'(bus.fill_o),        32'(1));
        chk("req034_ready", 32'(bus.issue_ready_o), 32'(1));
        step();

        // Reset with two stored and one outstanding.
        do_reset();
        bus.issue_valid_i = 1'b1;
        step();
        step();
        step();
        idle();
        drive_res(32'h11111111, 5'h00, 2'd0);
        step();
        drive_res(32'h22222222, 5'h00, 2'd1);
        step();
        idle();
        chk("req035_pre_fill", 32'(bus.fill_o), 32'(2));
        do_reset();
        step();

        // Randomized traffic, mostly well-behaved with occasional spurious results.
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.issue_valid_i = ($urandom_range(0, 99) < 50);
            if (m_infl > 0 ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3))
                drive_res($urandom, SW'($urandom), TW'($urandom));
            bus.out_ready_i = ($urandom_range(0, 99) < 55);
            bus.clr_err_i   = ($urandom_range(0, 99) < 5);
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
